// File: rtl/spwm_multichannel.sv
// Multi-channel sine-triangle PWM generator: one shared symmetric carrier,
// per-channel reference compare, complementary gate outputs with dead time.
module spwm_multichannel #(
    parameter int CH   = 3,
    parameter int DW   = 16,
    parameter int DT_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [DW-1:0]     carrier_period,
    input  logic [DT_W-1:0]   dead_time,
    input  logic [CH*DW-1:0]  ref_data,
    input  logic              ref_valid,
    output logic              ref_ready,
    output logic [DW-1:0]     carrier_out,
    output logic              sync,
    output logic [CH-1:0]     pwm_h,
    output logic [CH-1:0]     pwm_l
);

    logic [DW-1:0]    carrier_r;
    logic [DW-1:0]    carrier_nxt_s;
    logic [DW-1:0]    p_shadow_r;
    logic             dir_up_r;
    logic             dir_up_nxt_s;
    logic             buf_full_r;
    logic             en_r;
    logic [CH*DW-1:0] buf_data_r;
    logic [CH*DW-1:0] ref_shadow_r;
    logic [CH-1:0]    raw_r;
    logic [CH-1:0]    raw_nxt_s;
    logic [CH-1:0]    tgt_r;
    logic [CH-1:0]    event_s;
    logic [CH-1:0]    pwm_h_r;
    logic [CH-1:0]    pwm_l_r;
    logic [DT_W-1:0]  dead_cnt_r [CH];
    logic             valley_s;
    logic             accept_s;
    logic             p_small_s;

    assign valley_s    = enable && (carrier_r == {DW{1'b0}});
    assign accept_s    = ref_valid && !buf_full_r;
    assign p_small_s   = (p_shadow_r < DW'(2'd2));
    assign ref_ready   = !buf_full_r;
    assign carrier_out = carrier_r;
    assign sync        = resetn && valley_s;
    assign pwm_h       = pwm_h_r;
    assign pwm_l       = pwm_l_r;

    // Triangle carrier next state; a valley uses the freshly sampled period
    always_comb begin
        carrier_nxt_s = carrier_r;
        dir_up_nxt_s  = dir_up_r;
        if (!enable) begin
            carrier_nxt_s = {DW{1'b0}};
            dir_up_nxt_s  = 1'b1;
        end else if (valley_s) begin
            dir_up_nxt_s  = 1'b1;
            carrier_nxt_s = (carrier_period < DW'(2'd2)) ? {DW{1'b0}} : DW'(1'b1);
        end else if (dir_up_r && (carrier_r < p_shadow_r)) begin
            carrier_nxt_s = carrier_r + DW'(1'b1);
        end else begin
            dir_up_nxt_s  = 1'b0;
            carrier_nxt_s = carrier_r - DW'(1'b1);
        end
    end

    // Per-channel compare and switch-event detection (first enabled cycle counts as an event)
    always_comb begin
        raw_nxt_s = {CH{1'b0}};
        event_s   = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            raw_nxt_s[i] = enable && !p_small_s && (ref_shadow_r[i*DW +: DW] > carrier_r);
            event_s[i]   = (raw_r[i] != tgt_r[i]) || !en_r;
        end
    end

    // Carrier, period/reference shadows and the one-entry pending buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            carrier_r    <= {DW{1'b0}};
            dir_up_r     <= 1'b1;
            p_shadow_r   <= {DW{1'b0}};
            buf_full_r   <= 1'b0;
            buf_data_r   <= {(CH*DW){1'b0}};
            ref_shadow_r <= {(CH*DW){1'b0}};
            raw_r        <= {CH{1'b0}};
            en_r         <= 1'b0;
        end else begin
            carrier_r <= carrier_nxt_s;
            dir_up_r  <= dir_up_nxt_s;
            raw_r     <= raw_nxt_s;
            en_r      <= enable;
            if (valley_s) begin
                p_shadow_r <= carrier_period;
            end
            if (valley_s && buf_full_r) begin
                ref_shadow_r <= buf_data_r;
            end
            if (accept_s) begin
                buf_full_r <= 1'b1;
                buf_data_r <= ref_data;
            end else if (valley_s) begin
                buf_full_r <= 1'b0;
            end
        end
    end

    // Dead-time insertion: outputs stay off until the counter runs out, then follow the target
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tgt_r   <= {CH{1'b0}};
            pwm_h_r <= {CH{1'b0}};
            pwm_l_r <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                dead_cnt_r[i] <= {DT_W{1'b0}};
            end
        end else if (!enable) begin
            tgt_r   <= {CH{1'b0}};
            pwm_h_r <= {CH{1'b0}};
            pwm_l_r <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                dead_cnt_r[i] <= dead_time;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (event_s[i]) begin
                    tgt_r[i] <= raw_r[i];
                    if (dead_time == {DT_W{1'b0}}) begin
                        dead_cnt_r[i] <= {DT_W{1'b0}};
                        pwm_h_r[i]    <= raw_r[i];
                        pwm_l_r[i]    <= !raw_r[i];
                    end else begin
                        dead_cnt_r[i] <= dead_time;
                        pwm_h_r[i]    <= 1'b0;
                        pwm_l_r[i]    <= 1'b0;
                    end
                end else if (dead_cnt_r[i] > DT_W'(1'b1)) begin
                    dead_cnt_r[i] <= dead_cnt_r[i] - DT_W'(1'b1);
                    pwm_h_r[i]    <= 1'b0;
                    pwm_l_r[i]    <= 1'b0;
                end else begin
                    dead_cnt_r[i] <= {DT_W{1'b0}};
                    pwm_h_r[i]    <= tgt_r[i];
                    pwm_l_r[i]    <= !tgt_r[i];
                end
            end
        end
    end

endmodule
